csr_irq_ctrl: RTL and testbench

// - Machine-mode CSR file + interrupt controller for the 5-stage CPU; generalises the single-source CSR block.
// - Adds NUM_IRQ local interrupt lines, prioritised cause encoding, mcause, writable mtvec with direct/vectored mode,
//   and 64-bit mcycle/minstret counters. Sits beside ID/EX; drives PC redirect on trap entry and supplies mepc on mret.

---
 rtl/csr_irq_ctrl_if.sv | 41 ++++
 rtl/csr_irq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_csr_irq_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_irq_ctrl_if
// Bus bundle between the CPU pipeline (master) and the machine-mode CSR /
// interrupt controller (slave).
//   csr_addr/csr_wdata/csr_wen  CSR access from the pipeline (csr_rdata back)
//   retire/stall/nop/wfi/pc/mret  pipeline status at the trap point
//   ext_irq/tmr_irq/local_irq   level interrupt sources
//   trap_valid/trap_pc/mret_pc  redirect outputs towards the fetch stage
// ---------------------------------------------------------------------------
interface csr_irq_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [11:0]        csr_addr;
  logic [31:0]        csr_rdata;
  logic [31:0]        csr_wdata;
  logic               csr_wen;
  logic               retire;
  logic               stall;
  logic               nop;
  logic               wfi;
  logic [31:0]        pc;
  logic               mret;
  logic               ext_irq;
  logic               tmr_irq;
  logic [NUM_IRQ-1:0] local_irq;
  logic               trap_valid;
  logic [31:0]        trap_pc;
  logic [31:0]        mret_pc;

  modport master (
    output csr_addr, csr_wdata, csr_wen, retire, stall, nop, wfi, pc, mret,
           ext_irq, tmr_irq, local_irq,
    input  csr_rdata, trap_valid, trap_pc, mret_pc
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_wen, retire, stall, nop, wfi, pc, mret,
           ext_irq, tmr_irq, local_irq,
    output csr_rdata, trap_valid, trap_pc, mret_pc
  );
endinterface

// File: rtl/csr_irq_ctrl.sv
// ---------------------------------------------------------------------------
// csr_irq_ctrl
// Machine-mode CSR file and interrupt controller: mstatus, mie, mtvec
// (direct/vectored), mepc, mcause, mip, mcycle/minstret with prioritised
// interrupt entry, PC redirect on trap entry and mepc supply for mret.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   bus   slave modport of csr_irq_ctrl_if (CSR access, pipeline status,
//         interrupt lines, trap_valid/trap_pc/mret_pc outputs)
// ---------------------------------------------------------------------------
module csr_irq_ctrl #(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0001_0000,
  parameter int          CNT_W     = 64
) (
  input logic           clk,
  input logic           rst,
  csr_irq_ctrl_if.slave bus
);
  localparam int          HI_W     = CNT_W - 32;
  localparam logic [31:0] MIE_MASK = 32'h0000_0880 |
                                     (((32'h1 << NUM_IRQ) - 32'h1) << 16);

  typedef enum logic [1:0] {S_IDLE, S_TAKEN, S_ISR} state_e;

  state_e           state_q;
  logic             mstatus_mie_q, mstatus_mie_d;
  logic             mpie_q, mpie_d;
  logic [1:0]       mpp_q, mpp_d;
  logic [31:0]      mie_q, mie_d;
  logic [31:0]      mtvec_q, mtvec_d;
  logic [31:0]      mepc_q, mepc_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [4:0]       code_q, code_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;

  logic [31:0] mip_w, pend_w, pc4_w;
  logic [4:0]  code_w;
  logic        take_w, enter_w, commit_w, restore_w, wr_w;

  // Raw level inputs mirrored into mip; priority resolved lowest-wins first so
  // the later, higher-priority assignments override.
  always_comb begin
    mip_w                = '0;
    mip_w[11]            = bus.ext_irq;
    mip_w[7]             = bus.tmr_irq;
    mip_w[16 +: NUM_IRQ] = bus.local_irq;
    pend_w               = mip_w & mie_q;
    code_w               = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_w[16+i]) code_w = 5'(16 + i);
    end
    if (pend_w[7])  code_w = 5'd7;
    if (pend_w[11]) code_w = 5'd11;
  end

  assign take_w    = mstatus_mie_q & (|pend_w);
  assign enter_w   = (state_q == S_IDLE) & take_w & ~bus.stall;
  assign commit_w  = (state_q == S_TAKEN) & ~bus.nop & ~bus.stall;
  // A trap entry and an mret in the same IDLE cycle: the entry owns mstatus.
  assign restore_w = bus.mret & ~bus.stall &
                     ((state_q == S_ISR) | ((state_q == S_IDLE) & ~take_w));
  assign wr_w      = bus.csr_wen & ~bus.stall;
  assign pc4_w     = bus.pc + 32'd4;

  // Software writes first, hardware updates afterwards so they take priority.
  always_comb begin
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    mpp_d         = mpp_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    code_d        = code_q;
    mcycle_d      = mcycle_q + CNT_W'(1);
    minstret_d    = (bus.retire & ~bus.stall) ? minstret_q + CNT_W'(1) : minstret_q;
    if (wr_w) begin
      case (bus.csr_addr)
        12'h300: begin
          mstatus_mie_d = bus.csr_wdata[3];
          mpie_d        = bus.csr_wdata[7];
          mpp_d         = bus.csr_wdata[12:11];
        end
        12'h304: mie_d = bus.csr_wdata & MIE_MASK;
        // Only direct (00) and vectored (01) modes exist; anything else is direct.
        12'h305: mtvec_d = (bus.csr_wdata[1:0] == 2'b01) ? bus.csr_wdata
                                                         : (bus.csr_wdata & 32'hFFFF_FFFC);
        12'h341: mepc_d   = bus.csr_wdata & 32'hFFFF_FFFC;
        12'h342: mcause_d = bus.csr_wdata;
        // Writing one half blocks the increment; the other half holds.
        12'hB00: mcycle_d   = {mcycle_q[CNT_W-1:32], bus.csr_wdata};
        12'hB80: mcycle_d   = {bus.csr_wdata[HI_W-1:0], mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[CNT_W-1:32], bus.csr_wdata};
        12'hB82: minstret_d = {bus.csr_wdata[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end
    if (enter_w) begin
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
      mpp_d         = 2'b11;
      mcause_d      = {1'b1, 26'd0, code_w};
      code_d        = code_w;
    end
    if (commit_w) begin
      mepc_d = (bus.wfi ? pc4_w : bus.pc) & 32'hFFFF_FFFC;
    end
    if (restore_w) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
      mpp_d         = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= 2'b00;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RST;
      mepc_q        <= '0;
      mcause_q      <= '0;
      code_q        <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      mpp_q         <= mpp_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      code_q        <= code_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  // Cause is latched on entry; a source dropping during TAKEN has no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else if (!bus.stall) begin
      case (state_q)
        S_IDLE:  if (take_w)   state_q <= S_TAKEN;
        S_TAKEN: if (!bus.nop) state_q <= S_ISR;
        S_ISR:   if (bus.mret) state_q <= S_IDLE;
        default:               state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = {19'd0, mpp_q, 3'd0, mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      12'h304: bus.csr_rdata = mie_q;
      12'h305: bus.csr_rdata = mtvec_q;
      12'h341: bus.csr_rdata = mepc_q;
      12'h342: bus.csr_rdata = mcause_q;
      12'h344: bus.csr_rdata = mip_w;
      12'hB00: bus.csr_rdata = mcycle_q[31:0];
      12'hB80: bus.csr_rdata = 32'(mcycle_q[CNT_W-1:32]);
      12'hB02: bus.csr_rdata = minstret_q[31:0];
      12'hB82: bus.csr_rdata = 32'(minstret_q[CNT_W-1:32]);
      default: bus.csr_rdata = 32'd0;
    endcase
  end

  assign bus.trap_valid = commit_w;
  assign bus.trap_pc    = (mtvec_q[1:0] == 2'b01)
                          ? ({mtvec_q[31:2], 2'b00} + {25'd0, code_q, 2'b00})
                          : {mtvec_q[31:2], 2'b00};
  assign bus.mret_pc    = mepc_q;
endmodule

// File: tb/tb_csr_irq_ctrl.sv
module tb_csr_irq_ctrl;
  localparam int          NI       = 4;
  localparam logic [31:0] MIE_MASK = 32'h000F_0880;

  logic clk = 1'b0;
  logic rst_n;

  csr_irq_ctrl_if #(.NUM_IRQ(NI)) bus ();

  csr_irq_ctrl #(.NUM_IRQ(NI), .MTVEC_RST(32'h0001_0000), .CNT_W(64)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #50 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  // ---------------- reference model ----------------
  logic        m_ie_g, m_pie;
  logic [1:0]  m_pp;
  logic [31:0] m_mie, m_tvec, m_epc, m_cause;
  int          m_code, m_ph;             // phase 0 idle, 1 trap pending, 2 in handler
  longint unsigned m_cyc, m_ins;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (32'(bus.local_irq) << 16) | (32'(bus.ext_irq) << 11) | (32'(bus.tmr_irq) << 7);
  endfunction

  function automatic int m_pick(input logic [31:0] p);
    if (p[11]) return 11;
    if (p[7])  return 7;
    for (int i = 0; i < NI; i++) if (p[16+i]) return 16 + i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_pp) << 11) | (32'(m_pie) << 7) | (32'(m_ie_g) << 3);
      12'h304: return m_mie;
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h344: return m_mip();
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_ie_g = 0; m_pie = 0; m_pp = 0; m_mie = 0; m_tvec = 32'h0001_0000;
    m_epc = 0; m_cause = 0; m_code = 0; m_ph = 0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic m_step();
    logic [31:0] pend, w;
    int code, ph;
    bit take, enter, commit, rest, wr;
    logic old_ie, old_pie;
    longint unsigned cyc_n, ins_n;
    w = bus.csr_wdata;
    pend = m_mip() & m_mie;
    code = m_pick(pend);
    old_ie = m_ie_g; old_pie = m_pie; ph = m_ph;
    take   = old_ie && (code >= 0);
    enter  = (ph == 0) && take && !bus.stall;
    commit = (ph == 1) && !bus.nop && !bus.stall;
    rest   = bus.mret && !bus.stall && ((ph == 2) || ((ph == 0) && !take));
    wr     = bus.csr_wen && !bus.stall;
    cyc_n  = m_cyc + 1;
    ins_n  = m_ins + ((bus.retire && !bus.stall) ? 1 : 0);
    if (wr) begin
      case (bus.csr_addr)
        12'h300: begin m_ie_g = w[3]; m_pie = w[7]; m_pp = w[12:11]; end
        12'h304: m_mie = w & MIE_MASK;
        12'h305: m_tvec = (w[1:0] == 2'b01) ? w : (w & 32'hFFFF_FFFC);
        12'h341: m_epc = w & 32'hFFFF_FFFC;
        12'h342: m_cause = w;
        12'hB00: cyc_n = {m_cyc[63:32], w};
        12'hB80: cyc_n = {w, m_cyc[31:0]};
        12'hB02: ins_n = {m_ins[63:32], w};
        12'hB82: ins_n = {w, m_ins[31:0]};
        default: ;
      endcase
    end
    if (enter) begin
      m_pie = old_ie; m_ie_g = 0; m_pp = 2'b11;
      m_cause = 32'h8000_0000 | 32'(code); m_code = code; m_ph = 1;
    end
    if (commit) begin
      m_epc = (bus.wfi ? bus.pc + 32'd4 : bus.pc) & 32'hFFFF_FFFC;
      m_ph = 2;
    end
    if (rest) begin
      m_ie_g = old_pie; m_pie = 1; m_pp = 2'b11;
      if (ph == 2) m_ph = 0;
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0; bus.csr_wen = 1'b0;
    bus.retire = 1'b0; bus.stall = 1'b0; bus.nop = 1'b0; bus.wfi = 1'b0;
    bus.pc = 32'h0; bus.mret = 1'b0; bus.ext_irq = 1'b0; bus.tmr_irq = 1'b0;
    bus.local_irq = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr = a; bus.csr_wdata = d; bus.csr_wen = 1'b1;
    tick();
    bus.csr_wen = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    check(name, bus.csr_rdata, exp);
  endtask

  // compare outputs against the model, then advance one clock
  task automatic cyc();
    logic tv;
    #1;
    tv = (m_ph == 1) && !bus.nop && !bus.stall;
    check("rnd_rdata", bus.csr_rdata, m_read(bus.csr_addr));
    check("rnd_trap_valid", bus.trap_valid, tv);
    if (tv) check("rnd_trap_pc", bus.trap_pc,
                  (m_tvec[1:0] == 2'b01) ? (m_tvec & 32'hFFFF_FFFC) + 32'(4 * m_code)
                                         : (m_tvec & 32'hFFFF_FFFC));
    check("rnd_mret_pc", bus.mret_pc, m_epc);
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] addrs[11];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};

    // ---- reset values (checked while reset is held) ----
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    check("rst_trap_valid", bus.trap_valid, 1'b0);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mie",     12'h304, 32'h0);
    rd_chk("rst_mtvec",   12'h305, 32'h0001_0000);
    rd_chk("rst_mepc",    12'h341, 32'h0);
    rd_chk("rst_mcause",  12'h342, 32'h0);
    rd_chk("rst_mcycle",  12'hB00, 32'h0);
    rd_chk("rst_minstret",12'hB02, 32'h0);
    check("rst_mret_pc", bus.mret_pc, 32'h0);
    rst_n = 1'b1;

    // ---- table-driven CSR write/readback ----
    tbl.push_back('{12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1888});
    tbl.push_back('{12'h300, 32'h0000_0000, 1'b1, 32'h0000_1888});
    tbl.push_back('{12'h304, 32'hFFFF_FFFF, 1'b0, 32'h000F_0880});
    tbl.push_back('{12'h305, 32'h1234_5679, 1'b0, 32'h1234_5679});
    tbl.push_back('{12'h305, 32'h1234_567B, 1'b0, 32'h1234_5678});
    tbl.push_back('{12'h305, 32'h1234_567A, 1'b0, 32'h1234_5678});
    tbl.push_back('{12'h341, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC});
    tbl.push_back('{12'h342, 32'h8000_001F, 1'b0, 32'h8000_001F});
    tbl.push_back('{12'h344, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
    tbl.push_back('{12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
    tbl.push_back('{12'hB02, 32'h0000_0055, 1'b0, 32'h0000_0055});
    tbl.push_back('{12'hB82, 32'h0000_00AB, 1'b0, 32'h0000_00AB});
    tbl.push_back('{12'h304, 32'h0000_0000, 1'b1, 32'h000F_0880});
    foreach (tbl[i]) begin
      bus.stall = tbl[i].stall;
      csr_wr(tbl[i].addr, tbl[i].wdata);
      bus.stall = 1'b0;
      rd_chk($sformatf("tbl%0d_addr%0h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
    end

    // ---- external interrupt entry, write collision, no nesting, mret ----
    do_reset();
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    bus.ext_irq = 1'b1; bus.nop = 1'b0; bus.pc = 32'h0000_0200;
    bus.csr_addr = 12'h300; bus.csr_wdata = 32'h0; bus.csr_wen = 1'b1;
    tick();
    bus.csr_wen = 1'b0;
    check("s1_trap_valid", bus.trap_valid, 1'b1);
    check("s1_trap_pc", bus.trap_pc, 32'h0001_0000);
    bus.ext_irq = 1'b0;
    tick();
    check("s1_trap_one_cycle", bus.trap_valid, 1'b0);
    rd_chk("s1_mepc",    12'h341, 32'h0000_0200);
    rd_chk("s1_mcause",  12'h342, 32'h8000_000B);
    rd_chk("s1_mstatus", 12'h300, 32'h0000_1880);
    bus.ext_irq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("s4_no_nest", bus.trap_valid, 1'b0);
      tick();
    end
    bus.ext_irq = 1'b0; bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    rd_chk("s4_mstatus_restore", 12'h300, 32'h0000_1888);
    check("s4_mret_pc", bus.mret_pc, 32'h0000_0200);
    bus.ext_irq = 1'b1;
    tick();
    check("s4_idle_retake", bus.trap_valid, 1'b1);
    bus.ext_irq = 1'b0;

    // ---- vectored mode and priority ----
    do_reset();
    csr_wr(12'h305, 32'h0001_0001);
    csr_wr(12'h304, 32'h0003_0080);
    csr_wr(12'h300, 32'h0000_0008);
    bus.tmr_irq = 1'b1; bus.local_irq = 4'b0011;
    tick();
    check("s2_trap_valid", bus.trap_valid, 1'b1);
    check("s2_trap_pc", bus.trap_pc, 32'h0001_001C);
    rd_chk("s2_mcause", 12'h342, 32'h8000_0007);
    bus.tmr_irq = 1'b0;
    tick();
    rd_chk("s2_local_pending", 12'h344, 32'h0003_0000);
    bus.local_irq = '0;

    // ---- bubble at trap point, stall, WFI mepc ----
    do_reset();
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    bus.nop = 1'b1; bus.ext_irq = 1'b1;
    tick();
    bus.ext_irq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("s3_nop_hold", bus.trap_valid, 1'b0);
      tick();
    end
    bus.nop = 1'b0; bus.wfi = 1'b1; bus.pc = 32'h0000_0300; bus.stall = 1'b1;
    #1 check("s3_stall_hold", bus.trap_valid, 1'b0);
    tick();
    bus.stall = 1'b0;
    #1 check("s3_trap_valid", bus.trap_valid, 1'b1);
    check("s3_trap_pc", bus.trap_pc, 32'h0001_0000);
    tick();
    bus.wfi = 1'b0;
    rd_chk("s3_mepc_wfi", 12'h341, 32'h0000_0304);
    rd_chk("s3_mcause",   12'h342, 32'h8000_000B);
    check("s3_mret_pc", bus.mret_pc, 32'h0000_0304);

    // ---- counters ----
    do_reset();
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'h0000_0000);
    tick();
    rd_chk("c_mcycleh_carry", 12'hB80, 32'h0000_0001);
    rd_chk("c_mcycle_zero",   12'hB00, 32'h0000_0000);
    bus.retire = 1'b1; bus.stall = 1'b1;
    repeat (3) tick();
    rd_chk("c_minstret_stall", 12'hB02, 32'h0);
    bus.stall = 1'b0;
    repeat (2) tick();
    bus.retire = 1'b0;
    rd_chk("c_minstret_two", 12'hB02, 32'h2);
    bus.retire = 1'b1;
    csr_wr(12'hB02, 32'h0000_0010);
    bus.retire = 1'b0;
    rd_chk("c_minstret_wr_wins", 12'hB02, 32'h10);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'hFFFF_FFFF);
    tick();
    rd_chk("c_wrap_lo", 12'hB00, 32'h0);
    rd_chk("c_wrap_hi", 12'hB80, 32'h0);

    // ---- reset while a trap is pending ----
    do_reset();
    csr_wr(12'h305, 32'h0002_0001);
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    bus.nop = 1'b1; bus.ext_irq = 1'b1;
    tick();
    rst_n = 1'b0; bus.nop = 1'b0;
    #1 check("r_trap_valid_in_rst", bus.trap_valid, 1'b0);
    rd_chk("r_mtvec",   12'h305, 32'h0001_0000);
    rd_chk("r_mstatus", 12'h300, 32'h0);
    rd_chk("r_mie",     12'h304, 32'h0);
    rd_chk("r_mcause",  12'h342, 32'h0);
    tick();
    bus.ext_irq = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("r_no_trap_after", bus.trap_valid, 1'b0);
      tick();
    end

    // ---- randomized run against the reference model ----
    do_reset();
    bus.csr_wen = 1'b1; bus.csr_addr = 12'h304; bus.csr_wdata = 32'hFFFF_FFFF;
    cyc();
    bus.csr_addr = 12'h300; bus.csr_wdata = 32'h0000_0008;
    cyc();
    bus.csr_addr = 12'h305; bus.csr_wdata = 32'h0004_0001;
    cyc();
    for (int c = 0; c < 500; c++) begin
      bus.stall     = ($urandom_range(0, 5) == 0);
      bus.nop       = ($urandom_range(0, 2) == 0);
      bus.wfi       = ($urandom_range(0, 3) == 0);
      bus.pc        = $urandom;
      bus.mret      = ($urandom_range(0, 6) == 0);
      bus.ext_irq   = ($urandom_range(0, 3) == 0);
      bus.tmr_irq   = ($urandom_range(0, 3) == 0);
      bus.local_irq = 4'($urandom);
      bus.retire    = 1'($urandom);
      bus.csr_wen   = ($urandom_range(0, 5) == 0);
      bus.csr_addr  = addrs[$urandom_range(0, 10)];
      bus.csr_wdata = $urandom;
      cyc();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
